m68k_bus_responder: RTL

Target-side 68000 asynchronous bus responder: the counterpart to the CPLD's bus-master sequencer. It oversamples AS_n/UDS_n/LDS_n/R/W on the fast Pi clock, decodes a configurable address window, and runs one word or byte access against a simple backend memory request/ack port. It then terminates the 68000 cycle with DTACK_n, or with BERR_n on timeout. It serves as the on-board fast-RAM/register target and as the bus model for master-side verification.

---
 rtl/m68k_bus_pkg.sv | 29 ++
 rtl/m68k_sync.sv | 34 +++
 rtl/m68k_bus_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus responder slice.
// Holds the FSM state encoding, the IACK function code, byte-lane constants and the window decode.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_CAPTURE,
    S_ACCESS,
    S_WAIT,
    S_RELEASE,
    S_SKIP
  } state_t;

  localparam logic [2:0] FC_IACK  = 3'b111;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  // Word-address window match: only the masked bits have to equal the base.
  function automatic logic addrHit(input logic [22:0] a,
                                   input logic [22:0] base,
                                   input logic [22:0] mask);
    return ((a ^ base) & mask) == 23'd0;
  endfunction

endpackage

// File: rtl/m68k_sync.sv
// Two-flop synchronizer for one asynchronous bus strobe, plus a third flop for edge detection.
// The reset value matches the idle level of the strobe, so that leaving reset does not create a false edge.
module m68k_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/m68k_bus_responder.sv
// Target-side 68000 bus responder. It decodes an address window, runs one backend memory access,
// and ends the 68000 cycle with DTACK_n. If the backend never acknowledges, it ends the cycle with BERR_n.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE   = 24'h200000,
  parameter logic [23:0] ADDR_MASK   = 24'hE00000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        i_pi_clk,
  input  logic        i_reset,
  input  logic [22:0] i_m68k_a,
  input  logic [2:0]  i_m68k_fc,
  input  logic        i_m68k_as_n,
  input  logic        i_m68k_uds_n,
  input  logic        i_m68k_lds_n,
  input  logic        i_m68k_rw,
  input  logic [15:0] i_m68k_d_in,
  output logic [15:0] o_m68k_d_out,
  output logic        o_m68k_d_oe,
  output logic        o_m68k_dtack_n,
  output logic        o_m68k_berr_n,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [22:0] o_mem_addr,
  output logic [1:0]  o_mem_be,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  localparam logic [22:0] BASE_W       = ADDR_BASE[23:1];
  localparam logic [22:0] MASK_W       = ADDR_MASK[23:1];
  localparam logic [3:0]  WAIT_LAST    = 4'(WAIT_CYCLES);
  localparam logic [7:0]  TIMEOUT_LAST = TIMEOUT - 8'd1;

  logic w_asLevel, w_asRise, w_asFall;
  logic w_udsLevel, w_udsRise, w_udsFall;
  logic w_ldsLevel, w_ldsRise, w_ldsFall;
  logic w_rwLevel, w_rwRise, w_rwFall;
  logic w_unusedEdges;

  m68k_sync u_syncAs  (.i_clk(i_pi_clk), .i_reset(i_reset), .i_async(i_m68k_as_n),
                       .o_level(w_asLevel), .o_rise(w_asRise), .o_fall(w_asFall));
  m68k_sync u_syncUds (.i_clk(i_pi_clk), .i_reset(i_reset), .i_async(i_m68k_uds_n),
                       .o_level(w_udsLevel), .o_rise(w_udsRise), .o_fall(w_udsFall));
  m68k_sync u_syncLds (.i_clk(i_pi_clk), .i_reset(i_reset), .i_async(i_m68k_lds_n),
                       .o_level(w_ldsLevel), .o_rise(w_ldsRise), .o_fall(w_ldsFall));
  m68k_sync u_syncRw  (.i_clk(i_pi_clk), .i_reset(i_reset), .i_async(i_m68k_rw),
                       .o_level(w_rwLevel), .o_rise(w_rwRise), .o_fall(w_rwFall));

  assign w_unusedEdges = ^{w_asRise, w_udsRise, w_udsFall, w_ldsRise, w_ldsFall, w_rwRise, w_rwFall};

  logic [1:0] w_strobeBe;
  logic       w_hit;

  assign w_strobeBe = {~w_udsLevel, ~w_ldsLevel};
  assign w_hit      = addrHit(i_m68k_a, BASE_W, MASK_W) && (i_m68k_fc != FC_IACK);

  state_t      r_state;
  logic [7:0]  r_timeoutCnt;
  logic [3:0]  r_waitCnt;
  logic        r_abort;
  logic [15:0] r_dOut;
  logic        r_dOe;
  logic        r_dtackN;
  logic        r_berrN;
  logic        r_memReq;
  logic        r_memWe;
  logic [22:0] r_memAddr;
  logic [1:0]  r_memBe;
  logic [15:0] r_memWdata;

  // If the master aborts (AS goes high before the ack), the flag is sticky. The backend access still
  // completes, but the cycle is never terminated, even if a new AS arrives meanwhile.
  always_ff @(posedge i_pi_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_timeoutCnt <= 8'd0;
      r_waitCnt    <= 4'd0;
      r_abort      <= 1'b0;
      r_dOut       <= 16'd0;
      r_dOe        <= 1'b0;
      r_dtackN     <= 1'b1;
      r_berrN      <= 1'b1;
      r_memReq     <= 1'b0;
      r_memWe      <= 1'b0;
      r_memAddr    <= 23'd0;
      r_memBe      <= 2'b00;
      r_memWdata   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_asFall) r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (!w_hit)                    r_state <= S_SKIP;
          else if (w_asLevel)            r_state <= S_IDLE;
          else if (w_strobeBe != BE_NONE) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_memAddr    <= i_m68k_a;
          r_memWe      <= ~w_rwLevel;
          r_memBe      <= w_strobeBe;
          r_memWdata   <= i_m68k_d_in;
          r_memReq     <= 1'b1;
          r_timeoutCnt <= 8'd0;
          r_abort      <= 1'b0;
          r_state      <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_asLevel) r_abort <= 1'b1;
          if (i_mem_ack) begin
            r_memReq  <= 1'b0;
            r_waitCnt <= 4'd0;
            if (r_abort || w_asLevel) begin
              r_state <= S_IDLE;
            end else begin
              if (!r_memWe) r_dOut <= i_mem_rdata;
              r_state <= S_WAIT;
            end
          end else if (r_timeoutCnt == TIMEOUT_LAST) begin
            r_memReq <= 1'b0;
            if (r_abort || w_asLevel) begin
              r_state <= S_IDLE;
            end else begin
              r_berrN <= 1'b0;
              r_state <= S_RELEASE;
            end
          end else begin
            r_timeoutCnt <= r_timeoutCnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (w_asLevel) begin
            r_state <= S_IDLE;
          end else if (r_waitCnt == WAIT_LAST) begin
            r_dtackN <= 1'b0;
            r_dOe    <= ~r_memWe;
            r_state  <= S_RELEASE;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        S_RELEASE: begin
          if (w_asLevel) begin
            r_dtackN <= 1'b1;
            r_berrN  <= 1'b1;
            r_dOe    <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_SKIP: begin
          if (w_asLevel) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_m68k_d_out   = r_dOut;
  assign o_m68k_d_oe    = r_dOe;
  assign o_m68k_dtack_n = r_dtackN;
  assign o_m68k_berr_n  = r_berrN;
  assign o_mem_req      = r_memReq;
  assign o_mem_we       = r_memWe;
  assign o_mem_addr     = r_memAddr;
  assign o_mem_be       = r_memBe;
  assign o_mem_wdata    = r_memWdata;

endmodule
